// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the serial adder and its transaction front end.
package serial_add_pkg;

    localparam int unsigned DEF_WIDTH      = 8;
    localparam int unsigned DEF_ADD_CYCLES = 9;
    localparam int unsigned DEF_SETTLE     = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

    // Bits needed to hold a down-counter load value of max_val (never less than 1).
    function automatic int unsigned cnt_width(int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/serial_add_sequencer_if.sv
// Operand-in / result-out streams of the serial add sequencer.
interface serial_add_sequencer_if #(
    parameter int unsigned WIDTH = serial_add_pkg::DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
    logic             out_err;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_err
    );
endinterface

// File: rtl/serial_add_sequencer_cycle_counter.sv
// Loadable down-counter with a zero flag; shared by the RUN and SETTLE phases.
module cycle_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero_c
);

    logic [CNT_W-1:0] count;

    // Load wins over decrement; decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/serial_add_sequencer.sv
// Transaction front end: accepts operand pairs, sequences the serial adder, returns the result.
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned ADD_CYCLES = DEF_ADD_CYCLES,
    parameter int unsigned SETTLE     = DEF_SETTLE,
    parameter int unsigned COUNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    serial_add_sequencer_if.slave  bus,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    output logic                   add_clear,
    output logic                   add_start,
    input  logic [WIDTH:0]         add_sum,
    output logic [COUNT_W-1:0]     done_count
);

    localparam int unsigned SUM_W       = WIDTH + 1;
    localparam int unsigned RUN_LOAD    = (ADD_CYCLES > 0) ? ADD_CYCLES - 1 : 0;
    localparam int unsigned SETTLE_LOAD = (SETTLE > 0) ? SETTLE - 1 : 0;
    localparam int unsigned CNT_MAX     = (RUN_LOAD > SETTLE_LOAD) ? RUN_LOAD : SETTLE_LOAD;
    localparam int unsigned CNT_W       = cnt_width(CNT_MAX);

    seq_state_t       state, state_d;
    logic             accept_c, capture_c, handshake_c;
    logic             cnt_load_c, cnt_en_c, cnt_zero_c;
    logic [CNT_W-1:0] cnt_val_c;
    logic [SUM_W-1:0] sum_ref_c;
    logic             out_valid, out_err;
    logic [SUM_W-1:0] out_sum;

    cycle_counter #(.CNT_W(CNT_W)) u_cycle_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load_c),
        .load_val (cnt_val_c),
        .en       (cnt_en_c),
        .zero_c   (cnt_zero_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state decode plus the one-cycle control strobes for the datapath.
    always_comb begin
        state_d     = state;
        accept_c    = 1'b0;
        capture_c   = 1'b0;
        handshake_c = 1'b0;
        cnt_load_c  = 1'b0;
        cnt_en_c    = 1'b0;
        cnt_val_c   = '0;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    accept_c = 1'b1;
                    state_d  = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_load_c = 1'b1;
                cnt_val_c  = CNT_W'(RUN_LOAD);
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (!cnt_zero_c) begin
                    cnt_en_c = 1'b1;
                end else if (SETTLE == 0) begin
                    capture_c = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_load_c = 1'b1;
                    cnt_val_c  = CNT_W'(SETTLE_LOAD);
                    state_d    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!cnt_zero_c) begin
                    cnt_en_c = 1'b1;
                end else begin
                    capture_c = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    handshake_c = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reference sum for the adder cross-check, from the held operands.
    assign sum_ref_c = SUM_W'(add_a) + SUM_W'(add_b);

    // Operand hold, adder controls, result capture and completion count.
    always_ff @(posedge clk) begin
        if (reset) begin
            add_a      <= '0;
            add_b      <= '0;
            add_clear  <= 1'b0;
            add_start  <= 1'b0;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_err    <= 1'b0;
            done_count <= '0;
        end else begin
            add_clear <= (state_d == ST_CLEAR);
            add_start <= (state_d == ST_RUN);
            if (accept_c) begin
                add_a <= bus.in_a;
                add_b <= bus.in_b;
            end
            if (capture_c) begin
                out_sum   <= add_sum;
                out_err   <= (add_sum != sum_ref_c);
                out_valid <= 1'b1;
            end
            if (handshake_c) begin
                out_valid  <= 1'b0;
                done_count <= done_count + COUNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = out_valid;
    assign bus.out_sum   = out_sum;
    assign bus.out_err   = out_err;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer with a behavioural serial adder model.
module tb_serial_add_sequencer;

    localparam int unsigned W   = 8;
    localparam int unsigned AC  = 9;
    localparam int unsigned ST  = 1;
    localparam int unsigned CW  = 16;
    localparam int unsigned CW2 = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default configuration DUT
    serial_add_sequencer_if #(.WIDTH(W)) bus ();
    logic [W-1:0]  add_a, add_b;
    logic          add_clear, add_start;
    logic [W:0]    add_sum;
    logic [CW-1:0] done_count;
    logic          fault;
    int            st_cnt;

    serial_add_sequencer #(.WIDTH(W), .ADD_CYCLES(AC), .SETTLE(ST), .COUNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_clear  (add_clear),
        .add_start  (add_start),
        .add_sum    (add_sum),
        .done_count (done_count)
    );

    // Narrow counter, no settle DUT
    serial_add_sequencer_if #(.WIDTH(W)) bus_w ();
    logic [W-1:0]   add_a_w, add_b_w;
    logic           add_clear_w, add_start_w;
    logic [W:0]     add_sum_w;
    logic [CW2-1:0] done_count_w;
    int             st_cnt_w;

    serial_add_sequencer #(.WIDTH(W), .ADD_CYCLES(AC), .SETTLE(0), .COUNT_W(CW2)) dut_w (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_w),
        .add_a      (add_a_w),
        .add_b      (add_b_w),
        .add_clear  (add_clear_w),
        .add_start  (add_start_w),
        .add_sum    (add_sum_w),
        .done_count (done_count_w)
    );

    // Adder model: result is a+b once AC start cycles have run since the clear; garbage before.
    always @(posedge clk) begin
        if (add_clear) st_cnt <= 0;
        else if (add_start) st_cnt <= st_cnt + 1;
        if (add_clear_w) st_cnt_w <= 0;
        else if (add_start_w) st_cnt_w <= st_cnt_w + 1;
    end

    always_comb begin
        if (fault) add_sum = '0;
        else if (st_cnt + (add_start ? 1 : 0) >= int'(AC)) add_sum = {1'b0, add_a} + {1'b0, add_b};
        else add_sum = 9'h1AA;
        if (st_cnt_w + (add_start_w ? 1 : 0) >= int'(AC)) add_sum_w = {1'b0, add_a_w} + {1'b0, add_b_w};
        else add_sum_w = 9'h1AA;
    end

    // Measurements from one operation, all taken at falling edges
    int lat, nclear, nstart, first_start, both_hi, unstable;
    int exp_count;

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue one pair at a falling edge and watch the sequencer until out_valid (ends at a negedge).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic f);
        int g = 0;
        while (!bus.in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        fault        = f;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = W'($urandom);
        bus.in_b     = W'($urandom);
        nclear = 0; nstart = 0; first_start = -1; both_hi = 0; unstable = 0;
        lat = -1;
        for (int j = 0; j < 40; j++) begin
            if (add_clear) nclear++;
            if (add_start) begin
                nstart++;
                if (first_start < 0) first_start = j;
            end
            if (add_clear && add_start) both_hi++;
            if (add_a !== a || add_b !== b) unstable++;
            if (bus.out_valid) begin
                lat = j;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Accept the result after some idle cycles of out_ready=0 (ends at the negedge after the handshake).
    task automatic finish_op(input int delay);
        bus.out_ready = 1'b0;
        for (int i = 0; i < delay; i++) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        fault = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || add_clear !== 1'b0 || add_start !== 1'b0 ||
            bus.out_sum !== '0 || bus.out_err !== 1'b0 || add_a !== '0 || add_b !== '0 || done_count !== '0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b clr=%b start=%b sum=%h err=%b a=%h b=%h cnt=%0d required 1 0 0 0 000 0 00 00 0",
                     bus.in_ready, bus.out_valid, add_clear, add_start, bus.out_sum, bus.out_err, add_a, add_b, done_count);
        end
        checks++;
        if (done_count_w !== '0 || bus_w.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state_w: cnt=%0d in_ready=%b required 0 1", done_count_w, bus_w.in_ready);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_add();
        run_op(8'd200, 8'd100, 1'b0);
        checks++;
        if (lat !== 11) begin errors++; $display("FAIL basic_latency: got %0d required 11", lat); end
        checks++;
        if (bus.out_sum !== 9'h12C || bus.out_err !== 1'b0) begin
            errors++; $display("FAIL basic_sum: got %h err %b required 12c err 0", bus.out_sum, bus.out_err);
        end
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL basic_operands_stable: %0d unstable cycles required 0", unstable); end
        finish_op(0);
        exp_count = 1;
        checks++;
        if (done_count !== CW'(exp_count) || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_handshake: cnt=%0d out_valid=%b in_ready=%b required 1 0 1", done_count, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_max_operands();
        run_op(8'd255, 8'd255, 1'b0);
        checks++;
        if (bus.out_sum !== 9'h1FE || bus.out_err !== 1'b0) begin
            errors++; $display("FAIL max_sum: got %h err %b required 1fe err 0", bus.out_sum, bus.out_err);
        end
        checks++;
        if (nstart != int'(AC) || first_start != 1) begin
            errors++; $display("FAIL max_start_cycles: got %0d from %0d required %0d from 1", nstart, first_start, AC);
        end
        checks++;
        if (nclear != 1 || both_hi != 0) begin
            errors++; $display("FAIL max_clear_cycles: clear %0d overlap %0d required 1 0", nclear, both_hi);
        end
        finish_op(2);
        exp_count++;
        checks++;
        if (done_count !== CW'(exp_count)) begin errors++; $display("FAIL max_count: got %0d required %0d", done_count, exp_count); end
    endtask

    task automatic test_backpressure();
        int held_bad = 0;
        int j2 = -1;
        run_op(8'd17, 8'd42, 1'b0);
        bus.in_valid  = 1'b1;
        bus.in_a      = 8'd90;
        bus.in_b      = 8'd9;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_sum !== 9'd59 || bus.in_ready !== 1'b0 || add_a !== 8'd17) held_bad++;
        end
        checks++;
        if (held_bad != 0) begin errors++; $display("FAIL bp_hold: %0d bad cycles required 0", held_bad); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        exp_count++;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || done_count !== CW'(exp_count) || add_a !== 8'd17) begin
            errors++; $display("FAIL bp_handshake: out_valid=%b in_ready=%b cnt=%0d a=%0d required 0 1 %0d 17",
                               bus.out_valid, bus.in_ready, done_count, add_a, exp_count);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (add_a !== 8'd90 || add_b !== 8'd9 || bus.in_ready !== 1'b0 || add_clear !== 1'b1) begin
            errors++; $display("FAIL bp_second_accept: a=%0d b=%0d in_ready=%b clr=%b required 90 9 0 1", add_a, add_b, bus.in_ready, add_clear);
        end
        for (int j = 0; j < 40; j++) begin
            if (bus.out_valid) begin j2 = j; break; end
            @(negedge clk);
        end
        checks++;
        if (j2 != 11 || bus.out_sum !== 9'd99) begin
            errors++; $display("FAIL bp_second_result: lat %0d sum %0d required 11 99", j2, bus.out_sum);
        end
        finish_op(0);
        exp_count++;
    endtask

    task automatic test_faulty_adder();
        run_op(8'd3, 8'd4, 1'b1);
        checks++;
        if (bus.out_sum !== 9'd0 || bus.out_err !== 1'b1) begin
            errors++; $display("FAIL fault_flag: sum %h err %b required 000 err 1", bus.out_sum, bus.out_err);
        end
        finish_op(1);
        exp_count++;
        checks++;
        if (done_count !== CW'(exp_count)) begin errors++; $display("FAIL fault_count: got %0d required %0d", done_count, exp_count); end
    endtask

    task automatic test_reset_mid_run();
        int n = 0;
        int bad = 0;
        apply_reset();
        bus.in_valid = 1'b1;
        bus.in_a     = 8'd11;
        bus.in_b     = 8'd22;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int g = 0; g < 20 && n < 3; g++) begin
            @(negedge clk);
            if (add_start) n++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (n != 3 || add_start !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || add_a !== '0) begin
            errors++; $display("FAIL reset_mid_run: starts=%0d start=%b in_ready=%b out_valid=%b a=%0d required 3 0 1 0 0",
                               n, add_start, bus.in_ready, bus.out_valid, add_a);
        end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || add_start !== 1'b0 || bus.in_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || done_count !== '0) begin
            errors++; $display("FAIL reset_no_result: bad %0d cnt %0d required 0 0", bad, done_count);
        end
        exp_count = 0;
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic f;
        logic [W:0] exp_sum;
        for (int i = 0; i < 20; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            f = ($urandom_range(0, 3) == 0);
            exp_sum = f ? '0 : ((W+1)'(a) + (W+1)'(b));
            run_op(a, b, f);
            checks++;
            if (lat !== 11 || bus.out_sum !== exp_sum || bus.out_err !== f) begin
                errors++; $display("FAIL random_op%0d: lat %0d sum %h err %b required 11 %h %b", i, lat, bus.out_sum, bus.out_err, exp_sum, f);
            end
            finish_op(int'($urandom_range(0, 3)));
            exp_count++;
            checks++;
            if (done_count !== CW'(exp_count)) begin errors++; $display("FAIL random_count%0d: got %0d required %0d", i, done_count, exp_count); end
        end
    endtask

    task automatic test_back_to_back_wrap();
        logic [W-1:0] a, b;
        int lw;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            int g = 0;
            while (!bus_w.in_ready && g < 50) begin @(negedge clk); g++; end
            a = W'($urandom);
            b = W'($urandom);
            bus_w.in_valid = 1'b1;
            bus_w.in_a     = a;
            bus_w.in_b     = b;
            @(negedge clk);
            bus_w.in_valid = 1'b0;
            lw = -1;
            for (int j = 0; j < 40; j++) begin
                if (bus_w.out_valid) begin lw = j; break; end
                @(negedge clk);
            end
            checks++;
            if (lw != 10 || bus_w.out_sum !== ((W+1)'(a) + (W+1)'(b)) || bus_w.out_err !== 1'b0) begin
                errors++; $display("FAIL wrap_op%0d: lat %0d sum %h err %b required 10 %h 0", k, lw, bus_w.out_sum, bus_w.out_err, (W+1)'(a) + (W+1)'(b));
            end
            bus_w.out_ready = 1'b1;
            @(negedge clk);
            bus_w.out_ready = 1'b0;
            checks++;
            if (done_count_w !== CW2'((k + 1) % 4)) begin
                errors++; $display("FAIL wrap_count%0d: got %0d required %0d", k, done_count_w, (k + 1) % 4);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        fault = 1'b0;
        st_cnt = 0;
        st_cnt_w = 0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        bus_w.in_valid = 1'b0; bus_w.in_a = '0; bus_w.in_b = '0; bus_w.out_ready = 1'b0;
        exp_count = 0;
        test_reset();
        test_basic_add();
        test_max_operands();
        test_backpressure();
        test_faulty_adder();
        test_reset_mid_run();
        test_random();
        test_back_to_back_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_sequencer.md
# serial_add_sequencer

Transaction-level front end for the 8-bit serial adder. Accepts operand pairs over a valid/ready handshake and holds them stable on the adder's operand inputs. It drives the adder's clear and start controls for a fixed cycle budget, then captures the 9-bit result. It presents that result downstream over valid/ready, together with an internal a+b cross-check flag and a completed-operation counter.

## Interface
Parameters:
- WIDTH, 8, operand width; result is WIDTH+1 bits
- ADD_CYCLES, 9, cycles add_start is held high per operation; must be >= 1
- SETTLE, 1, idle cycles between add_start falling and result capture; 0 allowed
- COUNT_W, 16, width of done_count

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer can accept a pair
- in_a, in_b  in  WIDTH  operands
- add_a, add_b  out  WIDTH  operands to adder, stable from CLEAR through DONE
- add_clear  out  1  adder carry/sum clear pulse
- add_start  out  1  adder run enable
- add_sum  in  WIDTH+1  adder result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  WIDTH+1  captured add_sum
- out_err  out  1  captured add_sum != in_a+in_b (WIDTH+1-bit compare)
- done_count  out  COUNT_W  completed output handshakes, wraps modulo 2^COUNT_W

## Operation
- States: IDLE, CLEAR, RUN, SETTLE, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_a/in_b into add_a/add_b and go to CLEAR.
- CLEAR: add_clear=1 for exactly one cycle, then go to RUN and load the counter with ADD_CYCLES-1.
- RUN: add_start=1. Count down; at 0, go to SETTLE, or go straight to capture if SETTLE=0.
- SETTLE: add_start=0 for SETTLE cycles.
- Capture: on the edge leaving the last RUN/SETTLE cycle, register out_sum<=add_sum, out_err<=(add_sum != {1'b0,add_a}+{1'b0,add_b}), out_valid<=1, state<=DONE.
- DONE: hold out_sum/out_err/out_valid. On out_valid&&out_ready, go to IDLE, clear out_valid and increment done_count.
- in_ready is 0 in every state except IDLE. No new pair is accepted in the same cycle as an output handshake.
- in_a/in_b changes outside the accept cycle are ignored.
- Reset, any state: next cycle state=IDLE and in_ready=1. All other outputs go to 0: add_clear, add_start, out_valid, out_err, out_sum, add_a, add_b, done_count. The in-flight operation is dropped with no output.
- Arithmetic: sum is unsigned with WIDTH+1 bits and no overflow is possible. done_count wraps from all-ones to 0 silently.

## Timing
- Accept edge = T0. add_clear is high in cycle T0..T1.
- add_start is high for ADD_CYCLES consecutive cycles starting at T1.
- out_valid rises at edge T0+1+ADD_CYCLES+SETTLE (11 with defaults).
- Best-case period is 1+ADD_CYCLES+SETTLE+1 DONE cycle+1 IDLE cycle = 13 cycles.
- add_clear and add_start are never high in the same cycle.
- add_start is never high outside RUN.
- Outputs are registered; there are no combinational in→out paths except in_ready, which is decoded from state.

## Structure
- Package serial_add_pkg holds the state enum (seq_state_t) and the default WIDTH/ADD_CYCLES/SETTLE constants, shared with the serial adder top.
- Sub-module cycle_counter: loadable down-counter with load value, enable and a zero flag. It is reused for both the RUN count and the SETTLE count.

## Test plan
- Bench uses a behavioural adder model that returns a+b after ADD_CYCLES start cycles.
- Basic add: in_a=200, in_b=100 → out_valid at T0+11, out_sum=9'h12C, out_err=0, done_count=1.
- Max operands: 255+255 → out_sum=9'h1FE, out_err=0. Check that add_start is high for exactly 9 cycles and add_clear for exactly 1.
- Backpressure: out_ready=0 for 20 cycles with in_valid held high on a second pair → out_valid and out_sum are held, in_ready=0, and the second pair is accepted only in the IDLE cycle after the handshake.
- Faulty adder: model forces add_sum=0 for 3+4 → out_sum=0, out_err=1.
- Reset mid-RUN (third add_start cycle) → next cycle add_start=0, in_ready=1, out_valid=0. No result appears and done_count stays 0.
- Counter wrap: COUNT_W=2, SETTLE=0, five back-to-back ops → done_count sequence 1,2,3,0,1, and each out_valid rises at T0+10.
